// File: rtl/rv_div_ctrl.sv
// rv_div_ctrl: RV64M divide sequencer between issue logic and a radix-4 SRT divider core.
//
// Decodes DIV/DIVU/REM/REMU (plus W forms), resolves divide-by-zero, signed overflow and
// unsigned divisors >= 2^63 locally, and otherwise hands the core legal signed 64-bit
// operands. An unsigned dividend >= 2^63 is halved before issue and the result is
// rebuilt with one restoring step in FIX.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_*                     request valid/ready, op, W flag, operands, destination tag
//   resp_*                    tagged result valid/ready port
//   div_vld_o/op1/op2         operands and valid to the core
//   div_ready_i/quo/rem       core ready and results
//
// Optional feature macro: RV_DIV_RESULT_CACHE_EN
//   Keeps the last core-computed quotient/remainder; a request with identical prepared
//   operands, signedness and W flag completes through FAST without using the core.
module rv_div_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_vld_i,
  output logic             req_rdy_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_w_i,
  input  logic [63:0]      req_a_i,
  input  logic [63:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_vld_o,
  input  logic             resp_rdy_i,
  output logic [63:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             div_vld_o,
  output logic [63:0]      div_op1_o,
  output logic [63:0]      div_op2_o,
  input  logic             div_ready_i,
  input  logic [63:0]      div_quo_i,
  input  logic [63:0]      div_rem_i
);

  typedef enum logic [2:0] {
    StIdle, StFast, StIssue, StWaitLo, StWaitHi, StFix, StResp
  } state_e;

  state_e r_state, w_state_nxt;

  logic             r_rem, r_w, r_fix, r_a0;
  logic [TAG_W-1:0] r_tag;
  logic [63:0]      r_b, r_q, r_r, r_op1, r_op2;

  logic        w_sgn, w_acc, w_bzero, w_ovf, w_ubig, w_fix, w_hit, w_fast;
  logic [63:0] w_a, w_b, w_fq, w_fr, w_c_q, w_c_r;
  logic [64:0] w_r2;
  logic        w_ge;
  logic [63:0] w_fix_q, w_fix_r, w_res;

  // Operand preparation: W forms extend bits [31:0] by the signedness of the op.
  assign w_sgn = ~req_op_i[0];
  assign w_a   = req_w_i ? {{32{w_sgn & req_a_i[31]}}, req_a_i[31:0]} : req_a_i;
  assign w_b   = req_w_i ? {{32{w_sgn & req_b_i[31]}}, req_b_i[31:0]} : req_b_i;
  assign w_acc = req_vld_i & req_rdy_o;

  assign w_bzero = (w_b == '0);
  assign w_ovf   = w_sgn & ~req_w_i & (w_a == 64'h8000_0000_0000_0000) & (w_b == '1);
  assign w_ubig  = ~w_sgn & ~req_w_i & w_b[63];
  // Only reachable for unsigned non-W with b[63]=0, since b[63]=1 is resolved in FAST.
  assign w_fix   = ~w_sgn & w_a[63];

`ifdef RV_DIV_RESULT_CACHE_EN
  logic        r_c_vld, r_c_sgn, r_c_w;
  logic [63:0] r_c_a, r_c_b, r_c_q, r_c_r;

  assign w_hit = r_c_vld & (r_c_a == w_a) & (r_c_b == w_b) & (r_c_sgn == w_sgn) &
                 (r_c_w == req_w_i);
  assign w_c_q = r_c_q;
  assign w_c_r = r_c_r;

  // Key is written at issue with valid cleared; valid is set once the core result is final.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_c_vld <= 1'b0;
      r_c_sgn <= 1'b0;
      r_c_w   <= 1'b0;
      r_c_a   <= '0;
      r_c_b   <= '0;
      r_c_q   <= '0;
      r_c_r   <= '0;
    end else if (r_state == StIdle && w_acc && !w_fast) begin
      r_c_vld <= 1'b0;
      r_c_sgn <= w_sgn;
      r_c_w   <= req_w_i;
      r_c_a   <= w_a;
      r_c_b   <= w_b;
    end else if (r_state == StWaitHi && div_ready_i && !r_fix) begin
      r_c_vld <= 1'b1;
      r_c_q   <= div_quo_i;
      r_c_r   <= div_rem_i;
    end else if (r_state == StFix) begin
      r_c_vld <= 1'b1;
      r_c_q   <= w_fix_q;
      r_c_r   <= w_fix_r;
    end
  end
`else
  assign w_hit = 1'b0;
  assign w_c_q = '0;
  assign w_c_r = '0;
`endif

  assign w_fast = w_bzero | w_ovf | w_ubig | w_hit;

  always_comb begin
    w_fq = '0;
    w_fr = '0;
    if (w_bzero) begin
      w_fq = '1;
      w_fr = w_a;
    end else if (w_ovf) begin
      w_fq = w_a;
      w_fr = '0;
    end else if (w_ubig) begin
      if (w_a >= w_b) begin
        w_fq = 64'd1;
        w_fr = w_a - w_b;
      end else begin
        w_fq = '0;
        w_fr = w_a;
      end
    end else if (w_hit) begin
      w_fq = w_c_q;
      w_fr = w_c_r;
    end
  end

  // Restoring step that undoes the dividend halving: r' < 2b, so one subtract suffices.
  assign w_r2    = {r_r, r_a0};
  assign w_ge    = (w_r2 >= {1'b0, r_b});
  assign w_fix_q = {r_q[62:0], 1'b0} + {63'd0, w_ge};
  assign w_fix_r = w_ge ? (w_r2[63:0] - r_b) : w_r2[63:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_rdy_o   = 1'b0;
    resp_vld_o  = 1'b0;
    div_vld_o   = 1'b0;
    case (r_state)
      StIdle: begin
        req_rdy_o = rstn;
        if (w_acc) w_state_nxt = w_fast ? StFast : StIssue;
      end
      StFast:   w_state_nxt = StResp;
      StIssue: begin
        div_vld_o = 1'b1;
        if (div_ready_i) w_state_nxt = StWaitLo;
      end
      StWaitLo: if (!div_ready_i) w_state_nxt = StWaitHi;
      StWaitHi: if (div_ready_i) w_state_nxt = r_fix ? StFix : StResp;
      StFix:    w_state_nxt = StResp;
      StResp: begin
        resp_vld_o = 1'b1;
        if (resp_rdy_i) w_state_nxt = StIdle;
      end
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rem <= 1'b0;
      r_w   <= 1'b0;
      r_fix <= 1'b0;
      r_a0  <= 1'b0;
      r_tag <= '0;
      r_b   <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_acc) begin
            r_rem <= req_op_i[1];
            r_w   <= req_w_i;
            r_tag <= req_tag_i;
            r_fix <= w_fix;
            r_a0  <= w_a[0];
            r_b   <= w_b;
            r_q   <= w_fq;
            r_r   <= w_fr;
            if (!w_fast) begin
              r_op1 <= w_fix ? (w_a >> 1) : w_a;
              r_op2 <= w_b;
            end
          end
        end
        StWaitHi: begin
          if (div_ready_i) begin
            r_q <= div_quo_i;
            r_r <= div_rem_i;
          end
        end
        StFix: begin
          r_q <= w_fix_q;
          r_r <= w_fix_r;
        end
        default: ;
      endcase
    end
  end

  assign w_res       = r_rem ? r_r : r_q;
  assign resp_data_o = r_w ? {{32{w_res[31]}}, w_res[31:0]} : w_res;
  assign resp_tag_o  = r_tag;
  assign div_op1_o   = r_op1;
  assign div_op2_o   = r_op2;

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Bench for rv_div_ctrl: behavioural SRT-core stand-in, RISC-V reference model,
// scoreboard queue filled at acceptance and drained by a response monitor.
module tb_rv_div_ctrl;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_vld_i = 1'b0;
  logic             req_rdy_o;
  logic [1:0]       req_op_i = '0;
  logic             req_w_i = 1'b0;
  logic [63:0]      req_a_i = '0;
  logic [63:0]      req_b_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             resp_vld_o;
  logic             resp_rdy_i = 1'b0;
  logic [63:0]      resp_data_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic             div_vld_o;
  logic [63:0]      div_op1_o, div_op2_o;
  logic             div_ready_i;
  logic [63:0]      div_quo_i, div_rem_i;

  rv_div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_vld_i  (req_vld_i),
    .req_rdy_o  (req_rdy_o),
    .req_op_i   (req_op_i),
    .req_w_i    (req_w_i),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .req_tag_i  (req_tag_i),
    .resp_vld_o (resp_vld_o),
    .resp_rdy_i (resp_rdy_i),
    .resp_data_o(resp_data_o),
    .resp_tag_o (resp_tag_o),
    .div_vld_o  (div_vld_o),
    .div_op1_o  (div_op1_o),
    .div_op2_o  (div_op2_o),
    .div_ready_i(div_ready_i),
    .div_quo_i  (div_quo_i),
    .div_rem_i  (div_rem_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               bp_mode = 2;   // 0 random backpressure, 1 hold off, 2 always ready
  int               lat_force = 0; // 0 means random core latency
  bit               no_core = 1'b0;
  logic [TAG_W-1:0] next_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics, written directly from the ISA rules.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r;
    logic [31:0] a32, b32, q32, r32, res32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0) begin
        q32 = '1;
        r32 = a32;
      end else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32;
        r32 = '0;
      end else if (!op[0]) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      res32 = op[1] ? r32 : q32;
      return {{32{res32[31]}}, res32};
    end
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v = '0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = {32'h0, v[31:0]};
      4: v = 64'($urandom_range(0, 20));
      5: v = 64'd0 - 64'($urandom_range(1, 20));
      6: v = {32'hFFFF_FFFF, v[31:0]};
      7: v = {1'b1, v[62:0]};
      default: ;
    endcase
    return v;
  endfunction

  // Behavioural signed divider core: ready drops on accept, returns after a latency.
  logic        c_rdy = 1'b1;
  int          c_cnt = 0;
  logic [63:0] c_a = '0, c_b = '0, c_q = '0, c_r = '0;
  assign div_ready_i = c_rdy;
  assign div_quo_i   = c_q;
  assign div_rem_i   = c_r;

  always @(posedge clk) begin
    if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        c_rdy <= 1'b1;
        c_q   <= $signed(c_a) / $signed(c_b);
        c_r   <= $signed(c_a) % $signed(c_b);
      end
    end else if (div_vld_o && c_rdy) begin
      c_rdy <= 1'b0;
      c_a   <= div_op1_o;
      c_b   <= div_op2_o;
      c_cnt <= (lat_force > 0) ? lat_force : int'($urandom_range(1, 6));
    end
  end

  // Core must only ever receive legal signed operands.
  always @(negedge clk) begin
    if (rstn && div_vld_o && c_rdy) begin
      check("core_op2_nonzero", 64'(div_op2_o == 0), 64'd0);
      check("core_no_overflow", 64'(div_op1_o == 64'h8000_0000_0000_0000 &&
                                    div_op2_o == 64'hFFFF_FFFF_FFFF_FFFF), 64'd0);
    end
    if (no_core) check("no_core_div_vld", 64'(div_vld_o), 64'd0);
  end

  // Response monitor / scoreboard drain.
  always @(negedge clk) begin
    if (rstn && resp_vld_o && resp_rdy_i) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'(resp_vld_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", resp_data_o, e.data);
        check("resp_tag", 64'(resp_tag_o), 64'(e.tag));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       resp_rdy_i = ($urandom_range(0, 3) != 0);
        1:       resp_rdy_i = 1'b0;
        default: resp_rdy_i = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_vld_i = 1'b1;
    req_op_i  = op;
    req_w_i   = w;
    req_a_i   = a;
    req_b_i   = b;
    req_tag_i = next_tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_rdy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.data = ref_model(op, w, a, b);
      e.tag  = next_tag;
      sb.push_back(e);
      next_tag = next_tag + 1'b1;
    end else begin
      check("req_accept_timeout", 64'(ok), 64'd1);
    end
    @(posedge clk);
    #1;
    req_vld_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy_o), 64'd0);
    check("rst_resp_vld", 64'(resp_vld_o), 64'd0);
    check("rst_div_vld", 64'(div_vld_o), 64'd0);
    check("rst_resp_data", resp_data_o, 64'd0);
    check("rst_resp_tag", 64'(resp_tag_o), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_req_rdy", 64'(req_rdy_o), 64'd1);

    // Directed cases
    send(2'b00, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    send(2'b10, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    send(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    send(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    wait_idle();

    // Divide by zero: two-cycle latency, core untouched
    no_core = 1'b1;
    send(2'b00, 1'b0, 64'd42, 64'd0);
    @(negedge clk);
    check("fast_lat_cycle1_vld", 64'(resp_vld_o), 64'd0);
    @(negedge clk);
    check("fast_lat_cycle2_vld", 64'(resp_vld_o), 64'd1);
    wait_idle();
    send(2'b10, 1'b0, 64'd42, 64'd0);
    send(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send(2'b01, 1'b0, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0001);
    send(2'b11, 1'b0, 64'h7000_0000_0000_0000, 64'h8000_0000_0000_0001);
    wait_idle();
    no_core = 1'b0;

    send(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    send(2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 64'd2);
    wait_idle();

    // Backpressure hold
    bp_mode = 1;
    send(2'b00, 1'b0, 64'd1000, 64'd3);
    for (int i = 0; i < 100; i++) begin
      if (resp_vld_o) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_vld", 64'(resp_vld_o), 64'd1);
      check("hold_req_rdy", 64'(req_rdy_o), 64'd0);
      if (sb.size() > 0) begin
        check("hold_resp_data", resp_data_o, sb[0].data);
        check("hold_resp_tag", 64'(resp_tag_o), 64'(sb[0].tag));
      end
      @(negedge clk);
    end
    bp_mode = 2;
    wait_idle();

    // Reset while waiting on the core
    lat_force = 25;
    send(2'b00, 1'b0, 64'd1000, 64'd7);
    for (int i = 0; i < 50; i++) begin
      if (!div_ready_i) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_resp_vld", 64'(resp_vld_o), 64'd0);
    check("midrst_div_vld", 64'(div_vld_o), 64'd0);
    check("midrst_req_rdy", 64'(req_rdy_o), 64'd0);
    check("midrst_resp_data", resp_data_o, 64'd0);
    check("midrst_resp_tag", 64'(resp_tag_o), 64'd0);
    check("midrst_div_op1", div_op1_o, 64'd0);
    check("midrst_div_op2", div_op2_o, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    lat_force = 0;
    @(posedge clk);
    #1;
    check("midrst_release_req_rdy", 64'(req_rdy_o), 64'd1);
    send(2'b10, 1'b0, 64'd1000, 64'd7);
    wait_idle();

    // Randomized traffic with random backpressure and core latency
    bp_mode = 0;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic       w;
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      send(op, w, rnd_op(), rnd_op());
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_div_ctrl.md
Name: rv_div_ctrl

Overview:
- RV64M divide sequencer between the execute-stage issue logic and the radix-4 SRT divider core.
- Decodes DIV/DIVU/REM/REMU and their W variants, and resolves special cases (divide-by-zero, signed overflow, unsigned divisor ≥ 2^63) without using the core.
- Normalises operands so the core only ever sees legal signed 64-bit operands.
- Drives the core's vld/ready handshake, applies the unsigned fix-up, and returns a tagged writeback through a valid/ready port.

Parameters:
- TAG_W, 5, width of destination-register tag carried with each request.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  request ready; high only in IDLE
- req_op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_w_i  in  1  W variant (32-bit)
- req_a_i  in  64  dividend (rs1)
- req_b_i  in  64  divisor (rs2)
- req_tag_i  in  TAG_W  destination tag
- resp_vld_o  out  1  result valid
- resp_rdy_i  in  1  writeback accepts result
- resp_data_o  out  64  result
- resp_tag_o  out  TAG_W  tag of result
- div_vld_o  out  1  to core vld_i
- div_op1_o  out  64  to core dividend
- div_op2_o  out  64  to core divisor
- div_ready_i  in  1  from core ready_o
- div_quo_i  in  64  from core quotient
- div_rem_i  in  64  from core remainder

Behaviour:
- Reset: resp_vld_o=0, div_vld_o=0, req_rdy_o=0 during reset and 1 from the first cycle after release; all data/tag outputs 0; state IDLE.
- Accept on req_vld_i&req_rdy_o; latch op, w, tag and the prepared operands.
- W operands: signed ops sign-extend bits [31:0]; unsigned ops zero-extend bits [31:0].
- W results: result bits [31:0] are sign-extended to 64.
- States: IDLE, FAST, ISSUE, WAIT_LO, WAIT_HI, FIX, RESP.
- IDLE→FAST when the request resolves without the core:
  - b==0: quotient all-ones, remainder = a (extended a for W).
  - Signed op, a==0x8000_0000_0000_0000, b==all-ones, non-W: quotient = a, remainder = 0.
  - Unsigned non-W with b[63]=1: q = (a≥b) ? 1 : 0, r = a − q·b.
- FAST→RESP next cycle. Request-to-resp_vld latency is 2 cycles.
- IDLE→ISSUE for all other requests. Core operands:
  - Signed, or unsigned with a[63]=0: a, b unchanged.
  - Unsigned with a[63]=1 (b[63]=0 guaranteed): a>>1, b; set fix flag.
- ISSUE: div_vld_o=1 and op1/op2 stable. Go to WAIT_LO when div_vld_o&div_ready_i.
- WAIT_LO: wait for div_ready_i=0, then go to WAIT_HI.
- WAIT_HI: on div_ready_i=1, capture div_quo_i/div_rem_i. Go to FIX if the fix flag is set, else RESP.
- FIX (one cycle):
  - q' = 2·q1, r' = 2·r1 + a[0].
  - If r' ≥ b (unsigned, 65-bit compare): q'+1, r'−b.
- RESP: resp_vld_o=1, data/tag held stable until resp_rdy_i. Then go to IDLE; req_rdy_o reasserts the following cycle.
- Result select: DIV/DIVU → quotient, REM/REMU → remainder.
- No request is accepted while busy (single outstanding operation).
- Reset mid-operation returns to IDLE and discards the in-flight result. A result returned later by the core while in IDLE is ignored.
- div_vld_o is never asserted outside ISSUE.

Optional Feature:
- Macro: RV_DIV_RESULT_CACHE_EN.
- With the macro:
  - Keep the last core-computed {a, b, signedness, w, quotient, remainder} in a valid-flagged cache.
  - A new request whose operands, signedness and w match takes IDLE→FAST with the cached quotient/remainder (e.g. DIV then REM on the same operands), skipping the core.
  - Cache is invalidated on reset.
- Without the macro: every non-special request goes through the core.

Test Plan:
- DIV a=100, b=−7 → resp_data=−14 (0xFFFF_FFFF_FFFF_FFF2); REM same operands → 2.
- DIVU a=0xFFFF_FFFF_FFFF_FFFF, b=3 → FIX path, resp_data=0x5555_5555_5555_5555; REMU → 0.
- DIV b=0, a=42 → all-ones, resp_vld 2 cycles after acceptance, div_vld_o never high; REM → 42.
- DIV a=0x8000_0000_0000_0000, b=−1 → resp_data=0x8000_0000_0000_0000; REM → 0.
- DIVW a=0x0000_0000_8000_0000, b=−1 → resp_data=0xFFFF_FFFF_8000_0000; REMUW a=0xFFFF_FFFF_FFFF_FFF7, b=2 → 1.
- Hold resp_rdy_i=0 for 5 cycles → resp_data/tag stable and req_rdy_o=0 throughout. Assert rstn=0 in WAIT_HI → all outputs reset, next request completes correctly.
